// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch FSM states
//   BYTE_W           : width of one instruction-memory byte
//   PC_INC           : constant increment fed to the external adder
//   DEFAULT_RESET_PC : default PC after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetch_state_e;

  localparam int          BYTE_W           = 8;
  localparam logic [7:0]  PC_INC           = 8'd1;
  localparam logic [7:0]  DEFAULT_RESET_PC = 8'h00;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its surroundings (instruction
// memory, external PC adder, decode stage, branch/jump redirect).
//   master : the fetch unit side
//   slave  : the environment side (memory, adder, decode, branch logic)
interface instr_fetch_unit_if #(
  parameter int BYTES_PER_INSTR = 4
);

  logic                         EN;
  logic                         MEM_REQ;
  logic [7:0]                   MEM_ADDR;
  logic                         MEM_RDY;
  logic [7:0]                   MEM_RDATA;
  logic [7:0]                   ADD_A;
  logic [7:0]                   ADD_B;
  logic [7:0]                   ADD_SUM;
  logic                         ADD_CO;
  logic [8*BYTES_PER_INSTR-1:0] INSTR;
  logic [7:0]                   INSTR_PC;
  logic                         INSTR_VALID;
  logic                         INSTR_READY;
  logic                         REDIRECT;
  logic [7:0]                   REDIRECT_PC;
  logic                         PC_WRAP;

  modport master (
    input  EN, MEM_RDY, MEM_RDATA, ADD_SUM, ADD_CO, INSTR_READY,
           REDIRECT, REDIRECT_PC,
    output MEM_REQ, MEM_ADDR, ADD_A, ADD_B, INSTR, INSTR_PC,
           INSTR_VALID, PC_WRAP
  );

  modport slave (
    output EN, MEM_RDY, MEM_RDATA, ADD_SUM, ADD_CO, INSTR_READY,
           REDIRECT, REDIRECT_PC,
    input  MEM_REQ, MEM_ADDR, ADD_A, ADD_B, INSTR, INSTR_PC,
           INSTR_VALID, PC_WRAP
  );

endinterface

// File: rtl/instr_byte_assembler.sv
// Collects instruction bytes into little-endian lanes.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : drop all collected bytes, restart at lane 0
//   wr_i, wdata_i : store wdata_i into the current lane and advance
//   last_o        : current lane is the final one of the instruction
//   word_o        : collected lanes with the incoming byte merged into the
//                   current lane, so the full word is ready on the last write
module instr_byte_assembler
  import fetch_pkg::*;
#(
  parameter int BYTES_PER_INSTR = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_i,
  input  logic                              wr_i,
  input  logic [BYTE_W-1:0]                 wdata_i,
  output logic                              last_o,
  output logic [BYTE_W*BYTES_PER_INSTR-1:0] word_o
);

  localparam int CNT_W = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;

  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [BYTES_PER_INSTR-1:0][BYTE_W-1:0]    lanes_q, lanes_d;
  logic [BYTES_PER_INSTR-1:0][BYTE_W-1:0]    merged;

  assign last_o = (cnt_q == CNT_W'(BYTES_PER_INSTR - 1));

  always_comb begin
    merged        = lanes_q;
    merged[cnt_q] = wdata_i;
  end

  assign word_o = merged;

  always_comb begin
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    if (clr_i) begin
      cnt_d   = '0;
      lanes_d = '0;
    end else if (wr_i) begin
      lanes_d[cnt_q] = wdata_i;
      cnt_d          = last_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage of the 8-bit MIPS core. Reads one
// instruction as BYTES_PER_INSTR sequential bytes, owns the PC (incremented
// through the external 8-bit adder), and hands the word to decode under a
// valid/ready handshake. A redirect reloads the PC and aborts any fetch.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   bus        : memory, adder, decode and redirect signals (master side)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int         BYTES_PER_INSTR = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  instr_fetch_unit_if.master bus
);

  localparam int INSTR_W = BYTE_W * BYTES_PER_INSTR;

  fetch_state_e        state_q, state_d;
  logic [7:0]          pc_q, pc_d;
  logic [7:0]          start_pc_q, start_pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [7:0]          instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;

  logic                asm_clr;
  logic                asm_wr;
  logic                asm_last;
  logic [INSTR_W-1:0]  asm_word;

  instr_byte_assembler #(
    .BYTES_PER_INSTR (BYTES_PER_INSTR)
  ) u_asm (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (asm_clr),
    .wr_i    (asm_wr),
    .wdata_i (bus.MEM_RDATA),
    .last_o  (asm_last),
    .word_o  (asm_word)
  );

  // The adder sits outside this block; its result is consumed in the same
  // cycle, so the operands must be the live PC.
  assign bus.ADD_A       = pc_q;
  assign bus.ADD_B       = PC_INC;
  assign bus.MEM_ADDR    = pc_q;
  assign bus.MEM_REQ     = (state_q == FETCH);
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_PC    = instr_pc_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.PC_WRAP     = wrap_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    start_pc_d = start_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    wrap_d     = wrap_q;
    asm_clr    = 1'b0;
    asm_wr     = 1'b0;

    if (bus.REDIRECT) begin
      // Redirect wins over everything: a coincident memory byte and a
      // coincident decode handshake are both ignored.
      pc_d       = bus.REDIRECT_PC;
      start_pc_d = bus.REDIRECT_PC;
      valid_d    = 1'b0;
      asm_clr    = 1'b1;
      state_d    = bus.EN ? FETCH : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.EN) begin
            state_d    = FETCH;
            start_pc_d = pc_q;
            asm_clr    = 1'b1;
          end
        end
        FETCH: begin
          // EN is not looked at here: a started instruction always completes.
          if (bus.MEM_RDY) begin
            asm_wr = 1'b1;
            pc_d   = bus.ADD_SUM;
            if (bus.ADD_CO) wrap_d = 1'b1;
            if (asm_last) begin
              instr_d    = asm_word;
              instr_pc_d = start_pc_q;
              valid_d    = 1'b1;
              state_d    = VALID;
            end
          end
        end
        VALID: begin
          if (bus.INSTR_READY) begin
            valid_d = 1'b0;
            if (bus.EN) begin
              state_d    = FETCH;
              start_pc_d = pc_q;
              asm_clr    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      start_pc_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      start_pc_q <= start_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: byte memory and 8-bit adder models,
// scoreboard of expected instructions checked at each decode handshake,
// a table of fetch vectors plus hand-written multi-cycle sequences.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;

  typedef struct {
    logic [7:0]  start;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_instr;
    logic [7:0]  exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem [256];
  exp_t        sb [$];
  int          nvec = 0;
  int          nerr = 0;

  instr_fetch_unit_if #(.BYTES_PER_INSTR(4)) bus ();

  instr_fetch_unit #(
    .RESET_PC        (8'h00),
    .BYTES_PER_INSTR (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // External adder and byte memory models.
  assign {bus.ADD_CO, bus.ADD_SUM} = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B};
  assign bus.MEM_RDATA = bus.MEM_RDY ? mem[bus.MEM_ADDR] : 8'hEE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int budget, input bit rnd);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      if (rnd) bus.MEM_RDY = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    bus.MEM_RDY = 1'b1;
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL %s_timeout: %0d instructions outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  // Scoreboard: compare at every accepted handshake.
  always @(negedge clk) begin
    if (rst_n && bus.INSTR_VALID && bus.INSTR_READY && !bus.REDIRECT) begin
      exp_t e;
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_instr: got %h@%h expected none", bus.INSTR, bus.INSTR_PC);
      end else begin
        e = sb.pop_front();
        if (bus.INSTR !== e.instr || bus.INSTR_PC !== e.pc) begin
          nerr++;
          $display("FAIL sb_instr: got %h@%h expected %h@%h",
                   bus.INSTR, bus.INSTR_PC, e.instr, e.pc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [4];
    logic [31:0] held_instr;

    vecs[0] = '{8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF, 8'h80};
    vecs[1] = '{8'h20, 8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00, 8'h20};
    vecs[2] = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 8'hC3};
    vecs[3] = '{8'hF0, 8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678, 8'hF0};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h20;
    mem[4] = 8'hAA; mem[5] = 8'hBB; mem[6] = 8'hCC; mem[7] = 8'hDD;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;

    // Reset with EN and MEM_RDY high.
    rst_n = 1'b0;
    bus.EN = 1'b1; bus.MEM_RDY = 1'b1; bus.INSTR_READY = 1'b1;
    bus.REDIRECT = 1'b0; bus.REDIRECT_PC = 8'h00;
    step();
    chk("rst_mem_req",   32'(bus.MEM_REQ),     32'h0);
    chk("rst_mem_addr",  32'(bus.MEM_ADDR),    32'h00);
    chk("rst_add_a",     32'(bus.ADD_A),       32'h00);
    chk("rst_add_b",     32'(bus.ADD_B),       32'h01);
    chk("rst_instr",     bus.INSTR,            32'h0);
    chk("rst_instr_pc",  32'(bus.INSTR_PC),    32'h0);
    chk("rst_valid",     32'(bus.INSTR_VALID), 32'h0);
    chk("rst_wrap",      32'(bus.PC_WRAP),     32'h0);

    // Back-to-back fetch of two instructions, first-instruction latency.
    sb.push_back('{32'h2000018C, 8'h00});
    sb.push_back('{32'hDDCCBBAA, 8'h04});
    rst_n = 1'b1;
    step();
    chk("t1_req_after_release", 32'(bus.MEM_REQ), 32'h1);
    repeat (3) step();
    chk("t2_valid_early", 32'(bus.INSTR_VALID), 32'h0);
    step();
    chk("t2_valid_lat4", 32'(bus.INSTR_VALID), 32'h1);
    step();
    bus.EN = 1'b0;
    drain("t2", 40, 1'b0);

    // Two wait states on byte 1, then held in VALID for three cycles.
    sb.push_back('{32'h2000018C, 8'h00});
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 8'h00; bus.EN = 1'b1;
    bus.INSTR_READY = 1'b0;
    step();
    bus.REDIRECT = 1'b0; bus.EN = 1'b0;
    chk("t3_addr0", 32'(bus.MEM_ADDR), 32'h00);
    step();
    bus.MEM_RDY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_stall_addr", 32'(bus.MEM_ADDR), 32'h01);
      chk("t3_stall_req",  32'(bus.MEM_REQ),  32'h1);
      if (k < 2) step();
    end
    bus.MEM_RDY = 1'b1;
    step();
    step();
    chk("t3_valid_not_yet", 32'(bus.INSTR_VALID), 32'h0);
    step();
    chk("t3_valid_delayed", 32'(bus.INSTR_VALID), 32'h1);
    held_instr = 32'h2000018C;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_hold_instr", bus.INSTR,             held_instr);
      chk("t4_hold_pc",    32'(bus.INSTR_PC),     32'h00);
      chk("t4_hold_valid", 32'(bus.INSTR_VALID),  32'h1);
      chk("t4_hold_req",   32'(bus.MEM_REQ),      32'h0);
      chk("t4_hold_addr",  32'(bus.MEM_ADDR),     32'h04);
    end
    bus.INSTR_READY = 1'b1;
    step();
    chk("t4_accept_valid", 32'(bus.INSTR_VALID), 32'h0);
    step();
    chk("t4_idle_req", 32'(bus.MEM_REQ), 32'h0);
    chk("t4_sb_empty", 32'(sb.size()), 32'h0);

    // Redirect coincident with a memory byte after two bytes accepted.
    sb.push_back('{32'h44332211, 8'h40});
    bus.EN = 1'b1;
    step();
    bus.EN = 1'b0;
    step();
    step();
    chk("t5_addr_before", 32'(bus.MEM_ADDR), 32'h06);
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 8'h40; bus.EN = 1'b1;
    step();
    bus.REDIRECT = 1'b0; bus.EN = 1'b0;
    chk("t5_addr_redirect", 32'(bus.MEM_ADDR), 32'h40);
    chk("t5_req_redirect",  32'(bus.MEM_REQ),  32'h1);
    step();
    chk("t5_addr_next", 32'(bus.MEM_ADDR), 32'h41);
    drain("t5", 40, 1'b0);

    // Table of fetch vectors with random memory wait states.
    for (int v = 0; v < 4; v++) begin
      mem[vecs[v].start]              = vecs[v].b0;
      mem[8'(vecs[v].start + 8'd1)]   = vecs[v].b1;
      mem[8'(vecs[v].start + 8'd2)]   = vecs[v].b2;
      mem[8'(vecs[v].start + 8'd3)]   = vecs[v].b3;
      sb.push_back('{vecs[v].exp_instr, vecs[v].exp_pc});
      bus.REDIRECT = 1'b1; bus.REDIRECT_PC = vecs[v].start; bus.EN = 1'b1;
      bus.MEM_RDY = 1'($urandom_range(0, 1));
      step();
      bus.REDIRECT = 1'b0; bus.EN = 1'b0;
      drain("table", 200, 1'b1);
    end
    chk("table_no_wrap", 32'(bus.PC_WRAP), 32'h0);

    // Fetch across FF -> 00.
    mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34;
    sb.push_back('{32'h018C3412, 8'hFE});
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 8'hFE; bus.EN = 1'b1; bus.MEM_RDY = 1'b1;
    step();
    bus.REDIRECT = 1'b0; bus.EN = 1'b0;
    chk("t6_addr_fe", 32'(bus.MEM_ADDR), 32'hFE);
    step();
    chk("t6_addr_ff", 32'(bus.MEM_ADDR), 32'hFF);
    chk("t6_wrap_before", 32'(bus.PC_WRAP), 32'h0);
    step();
    chk("t6_addr_00", 32'(bus.MEM_ADDR), 32'h00);
    chk("t6_wrap_set", 32'(bus.PC_WRAP), 32'h1);
    step();
    chk("t6_addr_01", 32'(bus.MEM_ADDR), 32'h01);
    drain("t6", 40, 1'b0);
    repeat (4) step();
    chk("t6_wrap_sticky", 32'(bus.PC_WRAP), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("t6_wrap_cleared", 32'(bus.PC_WRAP), 32'h0);
    chk("t6_pc_reset",     32'(bus.MEM_ADDR), 32'h00);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multi-cycle instruction fetch stage for the 8-bit MIPS core. It assembles one 32-bit instruction from four sequential byte reads of byte-wide instruction memory and holds it for the decode stage under a valid/ready handshake. The PC lives here. The existing 8-bit adder, instantiated beside this block at datapath level, computes the increment: this block drives its operands and consumes its SUM/CO. Branch/jump logic redirects the PC through a redirect port.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
BYTES_PER_INSTR, 4, bytes per instruction; INSTR width = 8*BYTES_PER_INSTR.

Ports:
CLK  in  1  single clock, rising edge.
RST_N  in  1  asynchronous, active-low reset.
EN  in  1  fetch enable.
MEM_REQ  out  1  byte read request.
MEM_ADDR  out  8  byte address (= PC).
MEM_RDY  in  1  read data valid this cycle.
MEM_RDATA  in  8  read byte.
ADD_A  out  8  adder operand A (= PC).
ADD_B  out  8  adder operand B (constant 8'd1).
ADD_SUM  in  8  adder SUM.
ADD_CO  in  1  adder carry-out.
INSTR  out  32  assembled instruction.
INSTR_PC  out  8  address of the instruction's first byte.
INSTR_VALID  out  1  INSTR/INSTR_PC valid.
INSTR_READY  in  1  decode accepts.
REDIRECT  in  1  load new PC, abort current fetch.
REDIRECT_PC  in  8  redirect target.
PC_WRAP  out  1  sticky: PC wrapped FF->00.

Behaviour:
- Reset (async, RST_N low): PC=RESET_PC, state IDLE, byte_cnt=0, INSTR=0, INSTR_PC=0, INSTR_VALID=0, PC_WRAP=0, MEM_REQ=0. MEM_ADDR/ADD_A follow PC (=RESET_PC). Reset mid-fetch discards all partial bytes.
- ADD_A=PC and ADD_B=8'd1 are combinational at all times. ADD_SUM/ADD_CO are sampled in the same cycle, with no register between this block and the adder.
- States: IDLE, FETCH, VALID.
- IDLE: MEM_REQ=0. If EN=1: go to FETCH, byte_cnt=0, start_pc<=PC.
- FETCH: MEM_REQ=1, MEM_ADDR=PC. Address stays stable while MEM_REQ=1 and MEM_RDY=0 (any number of wait states).
- On MEM_RDY=1 in FETCH:
  - byte lane byte_cnt<=MEM_RDATA (little-endian: byte 0 -> [7:0]);
  - PC<=ADD_SUM;
  - if ADD_CO=1, PC_WRAP<=1.
  - If byte_cnt==BYTES_PER_INSTR-1: INSTR<=assembled word, INSTR_PC<=start_pc, INSTR_VALID<=1, go to VALID. Otherwise byte_cnt++.
- EN deassertion during FETCH does not abort. The current instruction completes.
- VALID: MEM_REQ=0. INSTR, INSTR_PC and INSTR_VALID stay stable until INSTR_READY=1. On acceptance INSTR_VALID<=0:
  - EN=1: go to FETCH with byte_cnt=0, start_pc<=PC.
  - EN=0: go to IDLE.
- Latency and throughput with MEM_RDY and INSTR_READY tied high: INSTR_VALID rises 4 cycles after the first MEM_REQ cycle. One instruction per 5 cycles.
- REDIRECT=1 has highest priority in any state:
  - PC<=REDIRECT_PC, byte_cnt=0, start_pc<=REDIRECT_PC, INSTR_VALID<=0.
  - Bytes already assembled are discarded, and a coincident MEM_RDY is ignored (no PC increment, no byte stored).
  - An instruction held in VALID is dropped even if INSTR_READY=1 in the same cycle (no handshake).
  - Next state is FETCH if EN=1, else IDLE.
- PC wrap-around: FF+1=00 via adder CO. Fetch continues normally across the wrap; only reset clears PC_WRAP.
- INSTR_VALID is never asserted with a partially assembled word.

Decomposition:
- Package fetch_pkg: state typedef {IDLE, FETCH, VALID}, BYTE_W=8, PC_INC=8'd1, default RESET_PC.
- One natural sub-module, instr_byte_assembler: byte_cnt plus lane-write register with clear, driven by the FSM.
- The adder stays external and is connected at datapath level.

Test Plan:
1. RST_N low with EN=1 and MEM_RDY=1 -> all outputs 0 except MEM_ADDR=ADD_A=8'h00 and ADD_B=8'h01. After release with EN=1, MEM_REQ=1 next cycle.
2. Memory 00..07 = 8C,01,00,20,AA,BB,CC,DD with MEM_RDY=1 and INSTR_READY=1 -> INSTR=32'h2000018C with INSTR_PC=00 after 4 cycles, then INSTR=32'hDDCCBBAA with INSTR_PC=04.
3. MEM_RDY low 2 cycles while fetching byte 1 -> MEM_ADDR held at 01 with MEM_REQ=1, PC unchanged, INSTR_VALID delayed exactly 2 cycles.
4. INSTR_READY low 3 cycles in VALID -> INSTR/INSTR_PC stable, MEM_REQ=0, PC=04. Accept with EN=0 -> IDLE, MEM_REQ stays 0.
5. REDIRECT to 40 after 2 bytes accepted, coincident with MEM_RDY -> next MEM_ADDR=40, no PC increment. The next instruction is bytes 40..43 with INSTR_PC=40 and none of the earlier bytes.
6. REDIRECT_PC=FE -> addresses FE,FF,00,01, PC_WRAP=1 from the cycle after FF is accepted, INSTR_PC=FE. PC_WRAP stays 1 until RST_N pulse.
